// File: rtl/dwpe_pkg.sv
// Shared sizing helpers, types and the shift/ReLU/saturate function used by
// the depthwise-conv PE array.
package dwpe_pkg;

    localparam int MAXW = 128;

    typedef logic signed [31:0] pixel_t;
    typedef logic signed [67:0] acc_t;
    typedef enum logic {IDLE, ACCUM} win_state_t;

    function automatic int taps(input int k);
        return k * k;
    endfunction

    function automatic int tapw(input int k);
        return (k * k > 1) ? $clog2(k * k) : 1;
    endfunction

    function automatic int accw(input int dw, input int ww, input int k);
        return dw + ww + $clog2(k * k);
    endfunction

    // Arithmetic shift, optional ReLU, then clamp into a signed dw-bit range.
    function automatic logic signed [MAXW-1:0] sat_shift(
        input logic signed [MAXW-1:0] acc,
        input int                     shift,
        input int                     dw,
        input logic                   relu
    );
        logic signed [MAXW-1:0] v;
        logic signed [MAXW-1:0] hi;
        logic signed [MAXW-1:0] lo;
        v  = acc >>> shift;
        hi = $signed((MAXW'(1) << (dw - 1)) - MAXW'(1));
        lo = ~hi;
        if (relu && v[MAXW-1])
            v = '0;
        if (v > hi)
            v = hi;
        else if (v < lo)
            v = lo;
        return v;
    endfunction

endpackage

// File: rtl/dw_mac_lane.sv
// One depthwise PE: registered product, window accumulator, and the
// combinational shift/ReLU/saturate stage feeding the top's output register.
module dw_mac_lane
    import dwpe_pkg::*;
#(
    parameter int DW    = 32,
    parameter int WW    = 32,
    parameter int KSIZE = 3,
    parameter int SHIFT = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          mul_en,
    input  logic          acc_en,
    input  logic          acc_first,
    input  logic          relu,
    input  logic [DW-1:0] pixel,
    input  logic [WW-1:0] weight,
    output logic [DW-1:0] result
);

    localparam int PW = DW + WW;
    localparam int AW = accw(DW, WW, KSIZE);

    logic signed [PW-1:0]   prod;
    logic signed [AW-1:0]   acc;
    logic signed [MAXW-1:0] acc_wide;

    // The first tap of a window overwrites the accumulator so no clear cycle is needed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prod <= '0;
            acc  <= '0;
        end else begin
            if (mul_en)
                prod <= PW'($signed(pixel)) * PW'($signed(weight));
            if (acc_en)
                acc <= acc_first ? AW'(prod) : acc + AW'(prod);
        end
    end

    assign acc_wide = MAXW'(acc);
    assign result   = DW'(sat_shift(acc_wide, SHIFT, DW, relu));

endmodule

// File: rtl/dwconv_pe_array.sv
// Depthwise-conv PE array: tap counter, weight file, pipeline control,
// output handshake and sticky error flags around POY*POX MAC lanes.
module dwconv_pe_array
    import dwpe_pkg::*;
#(
    parameter int DW    = 32,
    parameter int WW    = 32,
    parameter int POY   = 3,
    parameter int POX   = 16,
    parameter int KSIZE = 3,
    parameter int SHIFT = 16,
    localparam int TAPS = taps(KSIZE),
    localparam int TAPW = tapw(KSIZE)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [POY-1:0][POX-1:0][DW-1:0] dwpixel_array,
    input  logic                            dwpe_ena,
    input  logic                            relu_en,
    input  logic                            flush,
    input  logic                            wgt_we,
    input  logic [TAPW-1:0]                 wgt_addr,
    input  logic [WW-1:0]                   wgt_data,
    output logic [POY-1:0][POX-1:0][DW-1:0] o_data,
    output logic                            o_valid,
    input  logic                            o_ready,
    output logic                            busy,
    output logic                            ovf_err,
    output logic                            wgt_err
);

    win_state_t      state;
    logic [TAPW-1:0] tap_cnt;
    logic            relu_win;
    logic            beat, first_tap, last_tap;
    logic            s1_valid, s1_first, s1_last, s1_relu;
    logic            s2_valid, s2_relu;
    logic            acc_en, load_out;
    logic [WW-1:0]   wgt_file [TAPS];
    logic [WW-1:0]   cur_wgt;
    logic [POY-1:0][POX-1:0][DW-1:0] lane_res;

    assign beat      = dwpe_ena && !flush;
    assign first_tap = (tap_cnt == '0);
    assign last_tap  = (tap_cnt == TAPW'(TAPS - 1));
    assign cur_wgt   = wgt_file[tap_cnt];
    assign acc_en    = s1_valid && !flush;
    assign load_out  = s2_valid && !flush;
    assign busy      = (state == ACCUM) || s1_valid || s2_valid;

    // Window FSM; ReLU mode is latched on the first beat and held for the window.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            tap_cnt  <= '0;
            relu_win <= 1'b0;
        end else if (flush) begin
            state   <= IDLE;
            tap_cnt <= '0;
        end else if (dwpe_ena) begin
            if (first_tap)
                relu_win <= relu_en;
            if (last_tap) begin
                state   <= IDLE;
                tap_cnt <= '0;
            end else begin
                state   <= ACCUM;
                tap_cnt <= tap_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_relu  <= 1'b0;
            s2_valid <= 1'b0;
            s2_relu  <= 1'b0;
        end else begin
            s1_valid <= beat;
            s1_first <= first_tap;
            s1_last  <= last_tap;
            s1_relu  <= first_tap ? relu_en : relu_win;
            s2_valid <= s1_valid && s1_last && !flush;
            if (s1_valid && s1_last)
                s2_relu <= s1_relu;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++)
                wgt_file[i] <= '0;
            wgt_err <= 1'b0;
        end else if (wgt_we) begin
            if (busy)
                wgt_err <= 1'b1;
            else if (int'(wgt_addr) < TAPS)
                wgt_file[wgt_addr] <= wgt_data;
        end
    end

    // A finished tile only replaces the output when the slot is empty or being drained.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_data  <= '0;
            o_valid <= 1'b0;
            ovf_err <= 1'b0;
        end else if (load_out) begin
            if (!o_valid || o_ready) begin
                o_data  <= lane_res;
                o_valid <= 1'b1;
            end else begin
                ovf_err <= 1'b1;
            end
        end else if (o_valid && o_ready) begin
            o_valid <= 1'b0;
        end
    end

    for (genvar y = 0; y < POY; y++) begin : g_row
        for (genvar x = 0; x < POX; x++) begin : g_col
            dw_mac_lane #(
                .DW    (DW),
                .WW    (WW),
                .KSIZE (KSIZE),
                .SHIFT (SHIFT)
            ) u_lane (
                .clk       (clk),
                .rst_n     (rst_n),
                .mul_en    (beat),
                .acc_en    (acc_en),
                .acc_first (s1_first),
                .relu      (s2_relu),
                .pixel     (dwpixel_array[y][x]),
                .weight    (cur_wgt),
                .result    (lane_res[y][x])
            );
        end
    end

endmodule

// File: tb/tb_dwconv_pe_array.sv
// Directed self-checking bench for dwconv_pe_array with hand-computed tiles.
module tb_dwconv_pe_array;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [2:0][15:0][31:0]  dwpixel_array;
    logic                    dwpe_ena, relu_en, flush, wgt_we;
    logic [3:0]              wgt_addr;
    logic [31:0]             wgt_data;
    logic [2:0][15:0][31:0]  o_data;
    logic                    o_valid, o_ready, busy, ovf_err, wgt_err;

    int total = 0;
    int bad   = 0;

    dwconv_pe_array dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .dwpixel_array (dwpixel_array),
        .dwpe_ena      (dwpe_ena),
        .relu_en       (relu_en),
        .flush         (flush),
        .wgt_we        (wgt_we),
        .wgt_addr      (wgt_addr),
        .wgt_data      (wgt_data),
        .o_data        (o_data),
        .o_valid       (o_valid),
        .o_ready       (o_ready),
        .busy          (busy),
        .ovf_err       (ovf_err),
        .wgt_err       (wgt_err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic setPixels(input logic [31:0] v);
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 16; x++)
                dwpixel_array[y][x] = v;
    endtask

    task automatic loadWeights(input logic [31:0] w);
        for (int i = 0; i < 9; i++) begin
            wgt_we   = 1'b1;
            wgt_addr = 4'(i);
            wgt_data = w;
            tick();
        end
        wgt_we = 1'b0;
    endtask

    // Nine consecutive beats of a uniform pixel value; returns just after the LAST edge.
    task automatic applyStimulus(input logic [31:0] pix, input logic relu);
        setPixels(pix);
        relu_en  = relu;
        dwpe_ena = 1'b1;
        for (int i = 0; i < 9; i++)
            tick();
        dwpe_ena = 1'b0;
    endtask

    task automatic acceptOutput;
        o_ready = 1'b1;
        tick();
        o_ready = 1'b0;
    endtask

    task automatic checkTile(input string tag, input logic [31:0] exp);
        checkOutput({tag, "_00"}, 64'(o_data[0][0]), 64'(exp));
        checkOutput({tag, "_17"}, 64'(o_data[1][7]), 64'(exp));
        checkOutput({tag, "_215"}, 64'(o_data[2][15]), 64'(exp));
    endtask

    initial begin
        rst_n    = 1'b0;
        dwpe_ena = 1'b0;
        relu_en  = 1'b0;
        flush    = 1'b0;
        wgt_we   = 1'b0;
        wgt_addr = '0;
        wgt_data = '0;
        o_ready  = 1'b0;
        setPixels(32'd0);
        tick();
        tick();
        checkOutput("rst_valid", 64'(o_valid), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_ovf", 64'(ovf_err), 64'd0);
        checkOutput("rst_wgterr", 64'(wgt_err), 64'd0);
        checkOutput("rst_data", 64'(o_data[0][0]), 64'd0);
        rst_n = 1'b1;
        tick();

        // Unit pixels with unity (Q16) weights sum to 9, visible two edges after LAST.
        loadWeights(32'h0001_0000);
        applyStimulus(32'd1, 1'b0);
        tick();
        checkOutput("t1_valid_n1", 64'(o_valid), 64'd0);
        tick();
        checkOutput("t1_valid_n2", 64'(o_valid), 64'd1);
        checkTile("t1_data", 32'd9);
        acceptOutput();
        checkOutput("t1_accepted", 64'(o_valid), 64'd0);

        applyStimulus(32'(-1000), 1'b1);
        tick();
        tick();
        checkTile("t2_relu", 32'd0);
        acceptOutput();
        applyStimulus(32'(-1000), 1'b0);
        tick();
        tick();
        checkTile("t2_neg", 32'(-9000));
        acceptOutput();

        loadWeights(32'h7FFF_FFFF);
        applyStimulus(32'h7FFF_FFFF, 1'b0);
        tick();
        tick();
        checkTile("t3_satpos", 32'h7FFF_FFFF);
        acceptOutput();
        loadWeights(32'(-32'sh7FFF_FFFF));
        applyStimulus(32'h7FFF_FFFF, 1'b0);
        tick();
        tick();
        checkTile("t3_satneg", 32'h8000_0000);
        acceptOutput();

        // Two windows with no bubble and a stalled consumer: the second tile is dropped.
        loadWeights(32'h0001_0000);
        applyStimulus(32'd2, 1'b0);
        applyStimulus(32'd3, 1'b0);
        tick();
        tick();
        checkOutput("t4_valid", 64'(o_valid), 64'd1);
        checkOutput("t4_ovf", 64'(ovf_err), 64'd1);
        checkTile("t4_held", 32'd18);
        acceptOutput();
        checkOutput("t4_drained", 64'(o_valid), 64'd0);

        setPixels(32'd5);
        dwpe_ena = 1'b1;
        for (int i = 0; i < 4; i++)
            tick();
        checkOutput("t5_busy_mid", 64'(busy), 64'd1);
        setPixels(32'd100);
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        dwpe_ena = 1'b0;
        applyStimulus(32'd1, 1'b0);
        tick();
        tick();
        checkOutput("t5_valid", 64'(o_valid), 64'd1);
        checkTile("t5_fresh", 32'd9);
        checkOutput("t5_busy_end", 64'(busy), 64'd0);
        acceptOutput();

        // Weight write to the last tap while busy must not change the tile.
        setPixels(32'd1);
        relu_en  = 1'b0;
        dwpe_ena = 1'b1;
        for (int i = 0; i < 9; i++) begin
            wgt_we   = (i == 3);
            wgt_addr = 4'd8;
            wgt_data = 32'd0;
            tick();
        end
        wgt_we   = 1'b0;
        dwpe_ena = 1'b0;
        tick();
        tick();
        checkOutput("t6_wgterr", 64'(wgt_err), 64'd1);
        checkTile("t6_unchanged", 32'd9);

        dwpe_ena = 1'b1;
        for (int i = 0; i < 4; i++)
            tick();
        rst_n    = 1'b0;
        dwpe_ena = 1'b0;
        tick();
        checkOutput("t6_rst_valid", 64'(o_valid), 64'd0);
        checkOutput("t6_rst_data", 64'(o_data[2][15]), 64'd0);
        checkOutput("t6_rst_busy", 64'(busy), 64'd0);
        checkOutput("t6_rst_ovf", 64'(ovf_err), 64'd0);
        checkOutput("t6_rst_wgterr", 64'(wgt_err), 64'd0);
        rst_n = 1'b1;
        tick();
        applyStimulus(32'd7, 1'b0);
        tick();
        tick();
        checkOutput("t6_postrst_valid", 64'(o_valid), 64'd1);
        checkTile("t6_zero_wgts", 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
